// File: rtl/mod_mul_barrett_pkg.sv
// Shared constants and mode encoding for the dual-mode Barrett twiddle multiplier
// and the modular adder stage that consumes its output word.
package mod_mul_barrett_pkg;

    localparam int unsigned KQ   = 3329;
    localparam int unsigned DQ   = 8380417;
    localparam int unsigned K_MU = 5039;      // floor(2^24 / KQ)
    localparam int unsigned D_MU = 8396807;   // floor(2^46 / DQ)
    localparam int unsigned LAT  = 4;

    localparam int K_W     = 12;
    localparam int D_W     = 24;
    localparam int K_RW    = 14;
    localparam int D_RW    = 25;
    localparam int K_XW    = 24;
    localparam int D_XW    = 48;
    localparam int K_MU_W  = 13;
    localparam int D_MU_W  = 24;
    localparam int K_SHIFT = 24;
    localparam int D_SHIFT = 46;

    typedef enum logic {
        MODE_K = 1'b0,
        MODE_D = 1'b1
    } mode_e;

endpackage

// File: rtl/mod_mul_barrett_if.sv
// Operand/result bundle between the butterfly sequencer and the Barrett multiplier.
interface mod_mul_barrett_if;
    import mod_mul_barrett_pkg::*;

    // No ready: an op is taken when in_valid=1 and stall=0; stall freezes every
    // stage, so out_valid/out_mode/result stay put for the whole stall.
    logic           stall;
    logic           in_valid;
    logic           mode;
    logic [D_W-1:0] a;
    logic [D_W-1:0] b;
    logic           out_valid;
    logic           out_mode;
    logic [D_W-1:0] result;

    modport master (
        output stall, in_valid, mode, a, b,
        input  out_valid, out_mode, result
    );

    modport slave (
        input  stall, in_valid, mode, a, b,
        output out_valid, out_mode, result
    );

endinterface

// File: rtl/mod_mul_barrett_lane.sv
// One Barrett lane: multiply, quotient estimate, remainder, final correction.
// Each stage loads only when its enable is high, so idle lanes keep their last value.
module mod_mul_barrett_lane #(
    parameter int          W     = 12,
    parameter int          RW    = 14,
    parameter int          SHIFT = 24,
    parameter int          MUW   = 13,
    parameter int unsigned Q     = 3329,
    parameter int unsigned MU    = 5039
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] res
);
    localparam int XW  = 2 * W;
    localparam int PW  = XW + MUW;
    localparam int QHW = PW - SHIFT;
    localparam int QQW = QHW + W;

    localparam logic [MUW-1:0] MU_V = MUW'(MU);
    localparam logic [W-1:0]   Q_V  = W'(Q);
    localparam logic [RW-1:0]  Q1   = RW'(Q);
    localparam logic [RW-1:0]  Q2   = RW'(2 * Q);

    logic [XW-1:0]  x_s1;
    logic [RW-1:0]  x_s2;
    logic [QHW-1:0] qh_s2;
    logic [RW-1:0]  r_s3;
    logic [QHW-1:0] qh_next;
    logic [RW-1:0]  r_next;
    logic [RW-1:0]  r_fix;

    // The true remainder is below 3q < 2^RW, so computing it modulo 2^RW is exact.
    always_comb begin
        qh_next = QHW'((PW'(x_s1) * PW'(MU_V)) >> SHIFT);
        r_next  = x_s2 - RW'(QQW'(qh_s2) * QQW'(Q_V));
        r_fix   = r_s3;
        if (r_s3 >= Q2) begin
            r_fix = r_s3 - Q2;
        end else if (r_s3 >= Q1) begin
            r_fix = r_s3 - Q1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_s1  <= '0;
            x_s2  <= '0;
            qh_s2 <= '0;
            r_s3  <= '0;
            res   <= '0;
        end else begin
            if (en[0]) begin
                x_s1 <= XW'(a) * XW'(b);
            end
            if (en[1]) begin
                x_s2  <= x_s1[RW-1:0];
                qh_s2 <= qh_next;
            end
            if (en[2]) begin
                r_s3 <= r_next;
            end
            if (en[3]) begin
                res <= r_fix[W-1:0];
            end
        end
    end

endmodule

// File: rtl/mod_mul_barrett.sv
// Dual-mode pipelined modular multiplier: two 12-bit Kyber lanes or one 24-bit
// Dilithium lane, fixed four-cycle latency, global stall.
module mod_mul_barrett
    import mod_mul_barrett_pkg::*;
(
    input logic              clk,
    input logic              rst,
    mod_mul_barrett_if.slave bus
);
    logic [LAT-1:0] vld_q;
    logic [LAT-2:0] md_q;
    logic           out_mode_q;
    logic           act;
    logic [3:0]     en_k;
    logic [3:0]     en_d;
    logic [K_W-1:0] res_kh;
    logic [K_W-1:0] res_kl;
    logic [D_W-1:0] res_d;

    // A lane stage loads only for ops of its own mode, so the lane feeding the
    // output mux never changes under a bubble and result holds its last value.
    always_comb begin
        act  = !bus.stall;
        en_d = {vld_q[2] &  md_q[2],
                vld_q[1] &  md_q[1],
                vld_q[0] &  md_q[0],
                bus.in_valid & (bus.mode == MODE_D)} & {4{act}};
        en_k = {vld_q[2] & ~md_q[2],
                vld_q[1] & ~md_q[1],
                vld_q[0] & ~md_q[0],
                bus.in_valid & (bus.mode == MODE_K)} & {4{act}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q      <= '0;
            md_q       <= '0;
            out_mode_q <= MODE_K;
        end else if (act) begin
            vld_q <= {vld_q[LAT-2:0], bus.in_valid};
            md_q  <= {md_q[LAT-3:0], bus.mode};
            if (vld_q[LAT-2]) begin
                out_mode_q <= md_q[LAT-2];
            end
        end
    end

    mod_mul_barrett_lane #(
        .W(K_W), .RW(K_RW), .SHIFT(K_SHIFT), .MUW(K_MU_W), .Q(KQ), .MU(K_MU)
    ) u_lane_kh (
        .clk(clk), .rst(rst), .en(en_k),
        .a(bus.a[23:12]), .b(bus.b[23:12]), .res(res_kh)
    );

    mod_mul_barrett_lane #(
        .W(K_W), .RW(K_RW), .SHIFT(K_SHIFT), .MUW(K_MU_W), .Q(KQ), .MU(K_MU)
    ) u_lane_kl (
        .clk(clk), .rst(rst), .en(en_k),
        .a(bus.a[11:0]), .b(bus.b[11:0]), .res(res_kl)
    );

    mod_mul_barrett_lane #(
        .W(D_W), .RW(D_RW), .SHIFT(D_SHIFT), .MUW(D_MU_W), .Q(DQ), .MU(D_MU)
    ) u_lane_d (
        .clk(clk), .rst(rst), .en(en_d),
        .a(bus.a), .b(bus.b), .res(res_d)
    );

    assign bus.out_valid = vld_q[LAT-1];
    assign bus.out_mode  = out_mode_q;
    assign bus.result    = (out_mode_q == MODE_D) ? res_d : {res_kh, res_kl};

endmodule

// File: tb/tb_mod_mul_barrett.sv
// Bench for mod_mul_barrett: directed literal cases plus randomized traffic with
// stalls, checked every cycle against a queue-based arithmetic model.
module tb_mod_mul_barrett;
    import mod_mul_barrett_pkg::*;

    typedef struct packed {
        logic [31:0] due;
        logic        md;
        logic [23:0] res;
    } exp_t;

    logic clk;
    logic rst;
    mod_mul_barrett_if bus ();

    mod_mul_barrett dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    exp_t        exp_q[$];
    logic [31:0] act_cnt  = 0;
    logic [23:0] held_res = '0;
    logic        held_md  = 1'b0;
    logic        sb_ready = 1'b0;
    int          k_n = 0;
    int          d_n = 0;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference arithmetic ----------------
    function automatic logic [23:0] ref_mul(logic m, logic [23:0] a, logic [23:0] b);
        longint unsigned pa, pb, hi, lo, full;
        if (m) begin
            pa   = 64'(a);
            pb   = 64'(b);
            full = (pa * pb) % 64'(DQ);
            return full[23:0];
        end
        pa = 64'(a[23:12]);
        pb = 64'(b[23:12]);
        hi = (pa * pb) % 64'(KQ);
        pa = 64'(a[11:0]);
        pb = 64'(b[11:0]);
        lo = (pa * pb) % 64'(KQ);
        return {hi[11:0], lo[11:0]};
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- scoreboard: model update at posedge, compare at negedge ----------------
    initial begin : scoreboard
        exp_t e;
        logic exp_v;
        forever begin
            @(posedge clk);
            if (rst) begin
                exp_q.delete();
                act_cnt  = 0;
                held_res = '0;
                held_md  = 1'b0;
                sb_ready = 1'b1;
            end else if (sb_ready && !bus.stall) begin
                if (exp_q.size() > 0 && exp_q[0].due == act_cnt) begin
                    e        = exp_q.pop_front();
                    held_res = e.res;
                    held_md  = e.md;
                end
                act_cnt++;
                if (bus.in_valid) begin
                    e.due = act_cnt + LAT - 1;
                    e.md  = bus.mode;
                    e.res = ref_mul(bus.mode, bus.a, bus.b);
                    exp_q.push_back(e);
                end
            end
            @(negedge clk);
            if (sb_ready) begin
                exp_v = (exp_q.size() > 0) && (exp_q[0].due == act_cnt);
                check("sb_out_valid", 32'(bus.out_valid), 32'(exp_v));
                check("sb_result", 32'(bus.result), 32'(exp_v ? exp_q[0].res : held_res));
                check("sb_out_mode", 32'(bus.out_mode), 32'(exp_v ? exp_q[0].md : held_md));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(logic m, logic [23:0] a, logic [23:0] b);
        bus.stall    = 1'b0;
        bus.in_valid = 1'b1;
        bus.mode     = m;
        bus.a        = a;
        bus.b        = b;
        tick();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            bus.stall    = 1'b0;
            bus.in_valid = 1'b0;
            bus.mode     = 1'($urandom_range(1));
            bus.a        = 24'($urandom);
            bus.b        = 24'($urandom);
            tick();
        end
    endtask

    task automatic check_lit(string name, logic [23:0] want, logic m);
        @(negedge clk);
        check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        check(name, 32'(bus.result), 32'(want));
        check({name, "_mode"}, 32'(bus.out_mode), 32'(m));
    endtask

    task automatic check_zero(string name);
        @(negedge clk);
        check({name, "_valid"}, 32'(bus.out_valid), 32'd0);
        check(name, 32'(bus.result), 32'd0);
    endtask

    function automatic logic [23:0] rand_k();
        logic [11:0] h, l;
        h = ($urandom_range(3) == 0) ? 12'(4095 - $urandom_range(3)) : 12'($urandom_range(4095));
        l = ($urandom_range(3) == 0) ? 12'(3328 - $urandom_range(3)) : 12'($urandom_range(4095));
        return {h, l};
    endfunction

    function automatic logic [23:0] rand_d();
        if ($urandom_range(3) == 0) return 24'(DQ - 1 - $urandom_range(15));
        return 24'($urandom_range(DQ - 1));
    endfunction

    // ---------------- stimulus ----------------
    initial begin : main
        logic m;
        rst          = 1'b1;
        bus.stall    = 1'b0;
        bus.in_valid = 1'b0;
        bus.mode     = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        tick();
        tick();
        check_zero("reset_state");
        rst = 1'b0;

        // Kyber lanes {3328,2} x {3328,1665}
        issue(MODE_K, {12'd3328, 12'd2}, {12'd3328, 12'd1665});
        idle(3);
        check_lit("kyber_basic", 24'h001001, MODE_K);
        idle(2);

        // Dilithium triple back-to-back
        issue(MODE_D, 24'd8380416, 24'd8380415);
        issue(MODE_D, 24'd4190209, 24'd2);
        issue(MODE_D, 24'd0, 24'd8380416);
        idle(1);
        check_lit("dil_m1m2", 24'd2, MODE_D);
        idle(1);
        check_lit("dil_half", 24'd1, MODE_D);
        idle(1);
        check_lit("dil_zero", 24'd0, MODE_D);
        idle(2);

        // Mode switch on consecutive cycles
        issue(MODE_K, {12'd1, 12'd3328}, {12'd3328, 12'd3328});
        issue(MODE_D, 24'd8380416, 24'd8380416);
        idle(2);
        check_lit("mix_kyber", 24'hD00001, MODE_K);
        idle(1);
        check_lit("mix_dil", 24'd1, MODE_D);
        idle(2);

        // Two-cycle stall with three ops in flight; in_valid during stall is ignored
        issue(MODE_K, rand_k(), rand_k());
        issue(MODE_D, rand_d(), rand_d());
        issue(MODE_K, {12'd3328, 12'd2}, {12'd3328, 12'd1665});
        bus.stall    = 1'b1;
        bus.in_valid = 1'b1;
        bus.mode     = MODE_D;
        bus.a        = 24'd5;
        bus.b        = 24'd7;
        tick();
        tick();
        idle(6);

        // Reset with four ops in flight
        issue(MODE_D, rand_d(), rand_d());
        issue(MODE_K, rand_k(), rand_k());
        issue(MODE_D, rand_d(), rand_d());
        issue(MODE_K, rand_k(), rand_k());
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        check_zero("post_reset");
        idle(3);
        check_zero("post_reset_quiet");
        issue(MODE_D, 24'd8380416, 24'd8380415);
        idle(3);
        check_lit("after_reset_op", 24'd2, MODE_D);
        idle(2);

        // Randomized traffic with stalls and mode interleaving
        while (k_n < 10000 || d_n < 10000) begin
            m = 1'($urandom_range(1));
            if (m && d_n >= 10000) m = 1'b0;
            if (!m && k_n >= 10000) m = 1'b1;
            bus.stall    = ($urandom_range(9) == 0);
            bus.in_valid = ($urandom_range(4) != 0);
            bus.mode     = m;
            bus.a        = m ? rand_d() : rand_k();
            bus.b        = m ? rand_d() : rand_k();
            if (bus.in_valid && !bus.stall) begin
                if (m) d_n++;
                else   k_n++;
            end
            tick();
        end
        idle(8);
        @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
